// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolve inputs and PC-unit redirect handshake for branch_redirect_ctrl.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 64
);
  logic            ex_valid;
  logic            ex_is_branch;
  logic [1:0]      ex_jump_sel;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_tgt_imm;
  logic [XLEN-1:0] ex_tgt_jalr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  // Controller side: consumes EX resolution, issues the redirect request.
  modport master (
    input  ex_valid, ex_is_branch, ex_jump_sel, ex_pred_taken,
    input  ex_pc, ex_tgt_imm, ex_tgt_jalr, redirect_ready,
    output redirect_valid, redirect_pc
  );

  // Pipeline / PC-unit side.
  modport slave (
    output ex_valid, ex_is_branch, ex_jump_sel, ex_pred_taken,
    output ex_pc, ex_tgt_imm, ex_tgt_jalr, redirect_ready,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: 2-bit BHT direction predictor, mispredict
// detection against the EX branch judge, PC redirect handshake, pipeline
// flush timing and a saturating misprediction counter.
module branch_redirect_ctrl #(
  parameter int XLEN      = 64,
  parameter int BHT_IDX   = 6,
  parameter int FLUSH_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         if_pc,
  output logic                    if_pred_taken,
  branch_redirect_ctrl_if.master  bus,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic                    stall_ex,
  output logic [31:0]             mispred_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  localparam int BHT_N = 1 << BHT_IDX;
  localparam int CW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [1:0]         r_state;
  logic [XLEN-1:0]    r_redirect_pc;
  logic [CW-1:0]      r_flush_cnt;
  logic [31:0]        r_mispred_cnt;
  logic [1:0]         r_bht [BHT_N];

  logic [BHT_IDX-1:0] w_if_idx;
  logic [BHT_IDX-1:0] w_ex_idx;
  logic               w_taken;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_fallthrough;
  logic               w_resolve;
  logic               w_mispred;
  logic               w_bht_upd;
  logic               w_unused;

  assign w_if_idx      = if_pc[BHT_IDX+1:2];
  assign w_ex_idx      = bus.ex_pc[BHT_IDX+1:2];
  assign if_pred_taken = r_bht[w_if_idx][1];

  assign w_taken       = |bus.ex_jump_sel;
  assign w_target      = bus.ex_jump_sel[0] ? {bus.ex_tgt_jalr[XLEN-1:1], 1'b0}
                                            : bus.ex_tgt_imm;
  assign w_fallthrough = bus.ex_pc + XLEN'(4);
  assign w_resolve     = (r_state == S_IDLE) && bus.ex_valid;
  // Unconditional jumps are never predicted by the BHT, so they always redirect.
  assign w_mispred     = w_resolve && (bus.ex_is_branch ? (w_taken != bus.ex_pred_taken)
                                                        : 1'b1);
  assign w_bht_upd     = w_resolve && bus.ex_is_branch;

  assign w_unused = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0], bus.ex_tgt_jalr[0]};

  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;
  assign stall_ex           = (r_state == S_REDIRECT);
  assign flush_if_id        = (r_state != S_IDLE);
  assign flush_id_ex        = (r_state != S_IDLE);
  assign mispred_cnt        = r_mispred_cnt;

  // Redirect FSM: capture address on mispredict, hold until accepted, then
  // keep flushes up for FLUSH_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_redirect_pc <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mispred) begin
            r_state       <= S_REDIRECT;
            r_redirect_pc <= w_taken ? w_target : w_fallthrough;
          end
        end
        S_REDIRECT: begin
          if (bus.redirect_ready) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= CW'(FLUSH_CYC - 1);
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating misprediction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispred_cnt <= '0;
    end else if (w_mispred && (r_mispred_cnt != '1)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  // BHT training on resolved conditional branches; lookup sees the old value
  // in the update cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_upd) begin
      if (w_taken && (r_bht[w_ex_idx] != 2'b11)) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
      end else if (!w_taken && (r_bht[w_ex_idx] != 2'b00)) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
      end
    end
  end

endmodule
